systolic_array_ws: RTL and testbench

- Parametrised, weight-stationary NxN systolic matrix-vector engine; successor to the fixed 4x4 8-bit array.
- Adds signed arithmetic, a configurable accumulator width, internal input skew and output deskew, valid/ready flow control with backpressure, and double-buffered weights loaded row by row.
- Sits between the feature-map line buffer and the CNN accumulation/pooling stage.

---
 rtl/systolic_array_ws.sv | 166 ++++++++++++++++
 tb/tb_systolic_array_ws.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_ws.sv
// Weight-stationary NxN signed systolic matrix-vector engine with skew/deskew, backpressure
// and double-buffered weights. Define SYSTOLIC_RELU_EN to clamp negative outputs to zero.
module systolic_array_ws #(
    parameter  int ARRAY_SIZE = 4,
    parameter  int DATA_W     = 8,
    parameter  int ACC_W      = 20,
    localparam int ROW_W      = $clog2(ARRAY_SIZE)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ARRAY_SIZE*DATA_W-1:0] x_in,
    input  logic                         w_load_valid,
    input  logic [ROW_W-1:0]             w_load_row,
    input  logic [ARRAY_SIZE*DATA_W-1:0] w_load_data,
    input  logic                         w_commit,
    output logic                         commit_pending,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ARRAY_SIZE*ACC_W-1:0]  y_out,
    output logic                         busy
);
    localparam int N     = ARRAY_SIZE;
    localparam int CHAIN = 2 * N;

    typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_t;
    state_t state;

    logic signed [DATA_W-1:0] w_act [N][N];
    logic signed [DATA_W-1:0] w_sh  [N][N];
    logic signed [DATA_W-1:0] x_pe  [N][N];
    logic signed [ACC_W-1:0]  ps_pe [N][N];
    logic signed [DATA_W-1:0] row_x [N];
    logic signed [ACC_W-1:0]  col_y [N];
    logic [CHAIN-1:0]         vchain;
    logic                     stall;
    logic                     adv;
    logic                     accept;

    assign stall    = out_valid & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = ~stall & ~commit_pending & (state == RUN);
    assign accept   = in_valid & in_ready;
    assign busy     = (|vchain) | out_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= RUN;
            commit_pending <= 1'b0;
            for (int unsigned r = 0; r < N; r++)
                for (int unsigned c = 0; c < N; c++)
                    w_act[r][c] <= '0;
        end else begin
            case (state)
                RUN: if (w_commit) begin
                    state          <= DRAIN;
                    commit_pending <= 1'b1;
                end
                DRAIN: if (!busy) state <= SWAP;
                SWAP: begin
                    w_act          <= w_sh;
                    commit_pending <= 1'b0;
                    state          <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    // Shadow writes are independent of the FSM; a same-cycle SWAP copies the pre-write row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < N; r++)
                for (int unsigned c = 0; c < N; c++)
                    w_sh[r][c] <= '0;
        end else if (w_load_valid && (32'(w_load_row) < N)) begin
            for (int unsigned c = 0; c < N; c++)
                w_sh[w_load_row][c] <= w_load_data[c*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vchain    <= '0;
            out_valid <= 1'b0;
        end else if (adv) begin
            vchain    <= {vchain[CHAIN-2:0], accept};
            out_valid <= vchain[CHAIN-1];
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_skew
        logic signed [DATA_W-1:0] sk [r+1];
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int unsigned j = 0; j <= r; j++) sk[j] <= '0;
            end else if (adv) begin
                sk[0] <= accept ? x_in[r*DATA_W +: DATA_W] : '0;
                for (int unsigned j = 1; j <= r; j++) sk[j] <= sk[j-1];
            end
        end
        assign row_x[r] = sk[r];
    end

    for (genvar r = 0; r < N; r++) begin : g_pe_row
        for (genvar c = 0; c < N; c++) begin : g_pe_col
            logic signed [DATA_W-1:0]   xi;
            logic signed [ACC_W-1:0]    pi;
            logic signed [2*DATA_W-1:0] prod;
            if (c == 0) begin : g_xl
                assign xi = row_x[r];
            end else begin : g_xn
                assign xi = x_pe[r][c-1];
            end
            if (r == 0) begin : g_pt
                assign pi = '0;
            end else begin : g_pn
                assign pi = ps_pe[r-1][c];
            end
            assign prod = (2*DATA_W)'(xi) * (2*DATA_W)'(w_act[r][c]);
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    x_pe[r][c]  <= '0;
                    ps_pe[r][c] <= '0;
                end else if (adv) begin
                    x_pe[r][c]  <= xi;
                    ps_pe[r][c] <= pi + ACC_W'(prod);
                end
            end
        end
    end

    for (genvar c = 0; c < N; c++) begin : g_deskew
        localparam int D = N - 1 - c;
        if (D == 0) begin : g_direct
            assign col_y[c] = ps_pe[N-1][c];
        end else begin : g_dly
            logic signed [ACC_W-1:0] dk [D];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int unsigned j = 0; j < D; j++) dk[j] <= '0;
                end else if (adv) begin
                    dk[0] <= ps_pe[N-1][c];
                    for (int unsigned j = 1; j < D; j++) dk[j] <= dk[j-1];
                end
            end
            assign col_y[c] = dk[D-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_out <= '0;
        end else if (adv) begin
            for (int unsigned c = 0; c < N; c++) begin
`ifdef SYSTOLIC_RELU_EN
                y_out[c*ACC_W +: ACC_W] <= col_y[c][ACC_W-1] ? '0 : col_y[c];
`else
                y_out[c*ACC_W +: ACC_W] <= col_y[c];
`endif
            end
        end
    end

endmodule

// File: tb/tb_systolic_array_ws.sv
// Scoreboard bench for systolic_array_ws: reference model computes y = x*W with integer
// arithmetic; a negedge monitor pops expected vectors whenever a result is transferred.
module tb_systolic_array_ws;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 20;
    localparam int RW = $clog2(N);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [N*DW-1:0]   x_in;
    logic              w_load_valid;
    logic [RW-1:0]     w_load_row;
    logic [N*DW-1:0]   w_load_data;
    logic              w_commit;
    logic              commit_pending;
    logic              out_valid;
    logic              out_ready;
    logic [N*AW-1:0]   y_out;
    logic              busy;

    always #5 clk = ~clk;

    systolic_array_ws #(.ARRAY_SIZE(N), .DATA_W(DW), .ACC_W(AW)) dut (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
        .w_load_valid(w_load_valid), .w_load_row(w_load_row), .w_load_data(w_load_data),
        .w_commit(w_commit), .commit_pending(commit_pending), .out_valid(out_valid),
        .out_ready(out_ready), .y_out(y_out), .busy(busy)
    );

    int              total = 0;
    int              bad   = 0;
    int              wsh  [N][N];
    int              wact [N][N];
    logic [N*AW-1:0] exp_q [$];
    logic            rnd_ready = 1'b0;
    logic            held = 1'b0;
    logic [N*AW-1:0] held_y;
    logic [N*AW-1:0] mon_e;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic check_vec(input string name, input logic [N*AW-1:0] act, input logic [N*AW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    function automatic logic [N*AW-1:0] model(input int x[N]);
        logic [N*AW-1:0]   y;
        longint            s;
        logic signed [AW-1:0] t;
        y = '0;
        for (int c = 0; c < N; c++) begin
            s = 0;
            for (int r = 0; r < N; r++) s += longint'(x[r]) * longint'(wact[r][c]);
            t = AW'(s);
`ifdef SYSTOLIC_RELU_EN
            if (t < 0) t = '0;
`endif
            y[c*AW +: AW] = t;
        end
        return y;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (held && out_valid) check_vec("hold_stable", y_out, held_y);
            held   = out_valid && !out_ready;
            held_y = y_out;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got %h want none", y_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_vec("result", y_out, mon_e);
                end
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        #1;
    endtask

    task automatic load_row(input int r, input int v[N]);
        w_load_valid = 1'b1;
        w_load_row   = RW'(r);
        for (int c = 0; c < N; c++) begin
            w_load_data[c*DW +: DW] = DW'(v[c]);
            wsh[r][c] = v[c];
        end
        tick();
        w_load_valid = 1'b0;
    endtask

    task automatic wait_commit();
        int n = 0;
        logic last_busy = 1'b1;
        while (commit_pending && n < 500) begin
            check("in_ready_pending", in_ready, 0);
            last_busy = busy;
            tick();
            n++;
        end
        check("commit_clear", commit_pending, 0);
        check("busy_before_swap", last_busy, 0);
    endtask

    task automatic send(input int x[N], input logic with_commit);
        int n = 0;
        for (int r = 0; r < N; r++) x_in[r*DW +: DW] = DW'(x[r]);
        in_valid = 1'b1;
        while (!in_ready && n < 500) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready got 0 want 1");
        end else begin
            exp_q.push_back(model(x));
            if (with_commit) begin
                w_commit = 1'b1;
                wact = wsh;
            end
        end
        tick();
        in_valid = 1'b0;
        w_commit = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 500) begin
            tick();
            n++;
        end
        check("drain_queue", exp_q.size(), 0);
        check("drain_busy", busy, 0);
    endtask

    task automatic wait_out_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 50) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        int x[N];
        int v[N];
        int lat;
        int k;

        rst_n = 1'b0; in_valid = 1'b0; x_in = '0; w_load_valid = 1'b0; w_load_row = '0;
        w_load_data = '0; w_commit = 1'b0; out_ready = 1'b1;
        wsh = '{default: 0};
        wact = '{default: 0};
        #23;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_pending", commit_pending, 0);
        check_vec("rst_y", y_out, '0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 1);

        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) v[c] = 4 * r + c + 1;
            load_row(r, v);
        end
        w_commit = 1'b1; wact = wsh; tick(); w_commit = 1'b0;
        wait_commit();

        x = '{1, 2, 3, 4};
        send(x, 1'b0);
        wait_out_valid(lat);
        check("latency", lat, 2 * N);
        drain();

        x = '{-1, 0, 0, 0};
        send(x, 1'b0);
        drain();

        for (int i = 1; i <= 4; i++) begin
            x = '{i, 0, 0, 0};
            send(x, 1'b0);
        end
        wait_out_valid(lat);
        for (int i = 0; i < 4; i++) begin
            check("throughput_valid", out_valid, 1);
            tick();
        end
        drain();

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            x = '{rnd8(), rnd8(), rnd8(), rnd8()};
            send(x, 1'b0);
        end
        wait_out_valid(lat);
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            tick();
        end
        out_ready = 1'b1;
        drain();

        for (int r = 0; r < N; r++) begin
            v = '{2, 2, 2, 2};
            load_row(r, v);
        end
        x = '{3, -7, 11, 5};
        send(x, 1'b0);
        w_commit = 1'b1; wact = wsh; tick(); w_commit = 1'b0;
        check("hazard_pending", commit_pending, 1);
        wait_commit();
        x = '{1, 1, 1, 1};
        send(x, 1'b0);
        drain();

        rnd_ready = 1'b1;
        for (int it = 0; it < 60; it++) begin
            k = $urandom_range(0, 9);
            if (k < 3) begin
                for (int c = 0; c < N; c++) v[c] = rnd8();
                load_row($urandom_range(0, N - 1), v);
            end
            for (int r = 0; r < N; r++) x[r] = rnd8();
            send(x, k == 9);
            if (k == 9) wait_commit();
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        drain();

        for (int i = 0; i < 3; i++) begin
            x = '{i + 1, 2, 3, 4};
            send(x, 1'b0);
        end
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pending", commit_pending, 0);
        exp_q.delete();
        wsh = '{default: 0};
        wact = '{default: 0};
        #20;
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_valid", out_valid, 0);
        x = '{5, 5, 5, 5};
        send(x, 1'b0);
        drain();
        w_commit = 1'b1; wact = wsh; tick(); w_commit = 1'b0;
        wait_commit();
        send(x, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule
